// File: rtl/mfhwt_pingpong_linebuf.sv
// Ping-pong line buffer: two banks of NUM_ROWS x LINE_LEN pixels.
// Rows are written in raster order into one bank while the other bank is
// read out one column (all rows of that column) per accepted request.
module mfhwt_pingpong_linebuf #(
   parameter int DATA_W   = 16,
   parameter int LINE_LEN = 640,
   parameter int NUM_ROWS = 4
) (
   input  logic                       iClk,
   input  logic                       iReset,
   input  logic                       iClear,
   input  logic                       iWrValid,
   input  logic [DATA_W-1:0]          iData,
   output logic                       oWrReady,
   input  logic                       iRdreq,
   output logic                       oRdAvail,
   output logic                       oRdValid,
   output logic [NUM_ROWS*DATA_W-1:0] oData,
   output logic [1:0]                 oFull,
   output logic [1:0]                 oEmpty,
   output logic                       oWrBank,
   output logic                       oRdBank,
   output logic                       oOverflow
);

   localparam int COL_W = $clog2(LINE_LEN);
   localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

   typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_DRAINING} bank_st_t;

   bank_st_t                   st_q [2];
   bank_st_t                   st_d [2];
   logic                       wr_bank_q, wr_bank_d;
   logic                       rd_bank_q, rd_bank_d;
   logic [ROW_W-1:0]           wrow_q, wrow_d;
   logic [COL_W-1:0]           wcol_q, wcol_d;
   logic [COL_W-1:0]           rcol_q, rcol_d;
   logic [NUM_ROWS*DATA_W-1:0] data_q, data_d;
   logic                       rd_valid_q, rd_valid_d;
   logic                       ovf_q, ovf_d;
   logic [DATA_W-1:0]          mem_q [2][NUM_ROWS][LINE_LEN];
   logic [NUM_ROWS*DATA_W-1:0] col_rd;

   logic wr_ready, rd_avail, wr_acc, rd_acc, wr_last, rd_last;

   assign wr_ready = (st_q[wr_bank_q] == ST_EMPTY) || (st_q[wr_bank_q] == ST_FILLING);
   assign rd_avail = (st_q[rd_bank_q] == ST_FULL)  || (st_q[rd_bank_q] == ST_DRAINING);
   assign wr_acc   = iWrValid && wr_ready;
   assign rd_acc   = iRdreq && rd_avail;
   assign wr_last  = wr_acc && (wrow_q == ROW_LAST) && (wcol_q == COL_LAST);
   assign rd_last  = rd_acc && (rcol_q == COL_LAST);

   // Gather column rcol of every row of the read bank, row 0 in the LSBs
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_col
      assign col_rd[r*DATA_W +: DATA_W] = mem_q[rd_bank_q][r][rcol_q];
   end

   // Pixel storage; not reset, a clear only discards the bookkeeping
   always_ff @(posedge iClk) begin
      if (wr_acc && !iClear && !iReset) begin
         mem_q[wr_bank_q][wrow_q][wcol_q] <= iData;
      end
   end

   // Next-state: bank FSMs, write/read counters, bank toggles, read register
   always_comb begin
      st_d       = st_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wrow_d     = wrow_q;
      wcol_d     = wcol_q;
      rcol_d     = rcol_q;
      data_d     = data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;

      if (wr_acc) begin
         if (wcol_q == COL_LAST) begin
            wcol_d = '0;
            wrow_d = wrow_q + 1'b1;
         end else begin
            wcol_d = wcol_q + 1'b1;
         end
         if (wr_last) begin
            // Bank complete: hand it to the reader and move to the other bank
            st_d[wr_bank_q] = ST_FULL;
            wr_bank_d       = ~wr_bank_q;
            wrow_d          = '0;
            wcol_d          = '0;
         end else if (st_q[wr_bank_q] == ST_EMPTY) begin
            st_d[wr_bank_q] = ST_FILLING;
         end
      end

      if (iWrValid && !wr_ready) begin
         ovf_d = 1'b1;
      end

      // Read and write banks always differ, so both updates can apply together
      if (rd_acc) begin
         data_d     = col_rd;
         rd_valid_d = 1'b1;
         if (rd_last) begin
            st_d[rd_bank_q] = ST_EMPTY;
            rd_bank_d       = ~rd_bank_q;
            rcol_d          = '0;
         end else begin
            rcol_d = rcol_q + 1'b1;
            if (st_q[rd_bank_q] == ST_FULL) begin
               st_d[rd_bank_q] = ST_DRAINING;
            end
         end
      end

      if (iClear) begin
         st_d[0]    = ST_EMPTY;
         st_d[1]    = ST_EMPTY;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
         wrow_d     = '0;
         wcol_d     = '0;
         rcol_d     = '0;
         data_d     = '0;
         rd_valid_d = 1'b0;
         ovf_d      = 1'b0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         st_q[0]    <= ST_EMPTY;
         st_q[1]    <= ST_EMPTY;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wrow_q     <= '0;
         wcol_q     <= '0;
         rcol_q     <= '0;
         data_q     <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         st_q       <= st_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wrow_q     <= wrow_d;
         wcol_q     <= wcol_d;
         rcol_q     <= rcol_d;
         data_q     <= data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
      end
   end

   assign oWrReady  = wr_ready;
   assign oRdAvail  = rd_avail;
   assign oRdValid  = rd_valid_q;
   assign oData     = data_q;
   assign oWrBank   = wr_bank_q;
   assign oRdBank   = rd_bank_q;
   assign oOverflow = ovf_q;

   // Per-bank status flags
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         oFull[b]  = (st_q[b] == ST_FULL) || (st_q[b] == ST_DRAINING);
         oEmpty[b] = (st_q[b] == ST_EMPTY);
      end
   end

endmodule
